// File: rtl/veri_phase_comp_serial_host.sv
// Serial host bridge: 15-bit command frames in, register-file write strobes
// or read requests out, with serial read-back of the selected register.
module veri_phase_comp_serial_host #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sen,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              busy,
    output logic              frame_err,
    output logic [ADDR_W-1:0] reg_num,
    output logic              reg_write_readb,
    output logic [DATA_W-1:0] reg_load_data,
    input  logic [DATA_W-1:0] reg_read_data
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        WRITE,
        READ_CAP,
        SHIFT_OUT,
        WAIT_LOW
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-2:0]  in_q, in_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                sen_prev_q, sen_prev_d;
    logic                seen_low_q, seen_low_d;
    logic [FRAME_W-1:0]  frame;

    assign frame = {in_q, sdi};

    // seen_low keeps a sen level held high straight out of reset from
    // being mistaken for a frame start.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_d       = in_q;
        out_d      = out_q;
        num_d      = num_q;
        load_d     = load_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        sen_prev_d = sen;
        seen_low_d = seen_low_q | ~sen;
        unique case (state_q)
            IDLE: begin
                if (sen && !sen_prev_q && seen_low_q) begin
                    in_d    = {in_q[FRAME_W-3:0], sdi};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                if (!sen) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == LAST_IN) begin
                    num_d   = frame[FRAME_W-2 -: ADDR_W];
                    load_d  = frame[DATA_W-1:0];
                    cnt_d   = '0;
                    state_d = frame[FRAME_W-1] ? WRITE : READ_CAP;
                end else begin
                    in_d  = {in_q[FRAME_W-3:0], sdi};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                state_d = WAIT_LOW;
            end
            READ_CAP: begin
                out_d   = reg_read_data;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                out_d = {out_q[DATA_W-2:0], 1'b0};
                if (cnt_q == LAST_OUT) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!sen) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_q       <= '0;
            out_q      <= '0;
            num_q      <= '0;
            load_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            sen_prev_q <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            out_q      <= out_d;
            num_q      <= num_d;
            load_q     <= load_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            sen_prev_q <= sen_prev_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign reg_write_readb = (state_q == WRITE);
    assign busy            = (state_q != IDLE);
    assign sdo_valid       = valid_q;
    assign sdo             = valid_q & out_q[DATA_W-1];
    assign frame_err       = err_q;
    assign reg_num         = num_q;
    assign reg_load_data   = load_q;

endmodule

// File: tb/tb_veri_phase_comp_serial_host.sv
// Directed bench for the serial host bridge: vector table of write/read
// frames plus hand-written abort, held-enable, reset and back-to-back cases.
module tb_veri_phase_comp_serial_host;

    logic       clk;
    logic       resetb;
    logic       sen;
    logic       sdi;
    logic       sdo;
    logic       sdo_valid;
    logic       busy;
    logic       frame_err;
    logic [3:0] reg_num;
    logic       reg_write_readb;
    logic [9:0] reg_load_data;
    logic [9:0] reg_read_data;

    logic [9:0] mem [16];

    int tests;
    int fails;
    int strobe_cnt;
    int err_cnt;
    int viol_cnt;
    logic prev_strobe;

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [9:0] data;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [7];

    veri_phase_comp_serial_host #(
        .ADDR_W(4),
        .DATA_W(10)
    ) dut (
        .clk            (clk),
        .resetb         (resetb),
        .sen            (sen),
        .sdi            (sdi),
        .sdo            (sdo),
        .sdo_valid      (sdo_valid),
        .busy           (busy),
        .frame_err      (frame_err),
        .reg_num        (reg_num),
        .reg_write_readb(reg_write_readb),
        .reg_load_data  (reg_load_data),
        .reg_read_data  (reg_read_data)
    );

    assign reg_read_data = mem[reg_num];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file model plus protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_write_readb) begin
            strobe_cnt = strobe_cnt + 1;
            mem[reg_num] = reg_load_data;
            if (frame_err) viol_cnt = viol_cnt + 1;
            if (prev_strobe) viol_cnt = viol_cnt + 1;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (!sdo_valid && sdo) viol_cnt = viol_cnt + 1;
        prev_strobe = reg_write_readb;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [14:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            sen = 1'b1;
            sdi = f[14-i];
            tick();
        end
    endtask

    task automatic write_check(input logic [3:0] a, input logic [9:0] d,
                               input bit hold);
        int s0;
        s0 = strobe_cnt;
        drive_bits({1'b1, a, d}, 15);
        check("wr_strobe", reg_write_readb, 1);
        check("wr_num", reg_num, a);
        check("wr_data", reg_load_data, d);
        sen = hold;
        sdi = 1'b0;
        tick();
        check("wr_once", strobe_cnt - s0, 1);
        check("wr_busy_wait", busy, 1);
        sen = 1'b0;
        tick();
        check("wr_busy_idle", busy, 0);
    endtask

    task automatic read_check(input logic [3:0] a, input logic [9:0] exp);
        int s0;
        int nval;
        logic [9:0] got;
        s0 = strobe_cnt;
        nval = 0;
        got = '0;
        drive_bits({1'b0, a, 10'h000}, 15);
        check("rd_nostrobe", reg_write_readb, 0);
        check("rd_num", reg_num, a);
        check("rd_valid_cap", sdo_valid, 0);
        sen = 1'b0;
        sdi = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (sdo_valid) nval = nval + 1;
            got = {got[8:0], sdo};
        end
        check("rd_nvalid", nval, 10);
        check("rd_data", got, exp);
        tick();
        check("rd_valid_end", {sdo_valid, sdo}, 2'b00);
        check("rd_busy_wait", busy, 1);
        tick();
        check("rd_busy_idle", busy, 0);
        check("rd_no_strobe_total", strobe_cnt - s0, 0);
    endtask

    initial begin
        int s0;
        int busy_hits;
        tests = 0;
        fails = 0;
        strobe_cnt = 0;
        err_cnt = 0;
        viol_cnt = 0;
        prev_strobe = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 10'h2DB;
        mem[7] = 10'h1C3;
        mem[0] = 10'h0B6;

        vecs[0] = '{1'b1, 4'h5, 10'h2A5, 10'h2A5};
        vecs[1] = '{1'b0, 4'h7, 10'h000, 10'h1C3};
        vecs[2] = '{1'b1, 4'h3, 10'h000, 10'h000};
        vecs[3] = '{1'b0, 4'h3, 10'h000, 10'h000};
        vecs[4] = '{1'b1, 4'hA, 10'h3FF, 10'h3FF};
        vecs[5] = '{1'b0, 4'h5, 10'h000, 10'h2A5};
        vecs[6] = '{1'b0, 4'hA, 10'h000, 10'h3FF};

        // Reset with sen already high; it must not start a frame.
        resetb = 1'b0;
        sen = 1'b1;
        sdi = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs",
              {sdo, sdo_valid, busy, frame_err, reg_write_readb},
              5'b00000);
        check("rst_num", reg_num, 0);
        check("rst_data", reg_load_data, 0);
        resetb = 1'b1;
        busy_hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_hits = busy_hits + 1;
        end
        check("sen_high_from_reset", busy_hits, 0);
        check("sen_high_no_strobe", strobe_cnt, 0);
        sen = 1'b0;
        sdi = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) write_check(vecs[v].addr, vecs[v].data, 1'b0);
            else read_check(vecs[v].addr, vecs[v].exp);
        end

        // Abort after 9 bits.
        s0 = strobe_cnt;
        drive_bits({1'b1, 4'hC, 10'h111}, 9);
        sen = 1'b0;
        sdi = 1'b0;
        tick();
        check("abort_err", frame_err, 1);
        check("abort_busy", busy, 0);
        check("abort_num", reg_num, 4'hA);
        check("abort_data", reg_load_data, 10'h000);
        tick();
        check("abort_err_pulse", frame_err, 0);
        check("abort_err_cnt", err_cnt, 1);
        check("abort_no_strobe", strobe_cnt - s0, 0);
        write_check(4'hF, 10'h3FF, 1'b0);

        // Enable held for 20 bits on a write.
        s0 = strobe_cnt;
        drive_bits({1'b1, 4'h2, 10'h001}, 15);
        check("hold_strobe", reg_write_readb, 1);
        check("hold_num", reg_num, 4'h2);
        check("hold_data", reg_load_data, 10'h001);
        for (int i = 0; i < 5; i++) begin
            sen = 1'b1;
            sdi = 1'b1;
            tick();
        end
        check("hold_one_strobe", strobe_cnt - s0, 1);
        check("hold_busy", busy, 1);
        sen = 1'b0;
        sdi = 1'b0;
        tick();
        check("hold_idle", busy, 0);

        // Reset during the 4th shift-out bit.
        drive_bits({1'b0, 4'h7, 10'h000}, 15);
        sen = 1'b0;
        sdi = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", sdo_valid, 1);
        resetb = 1'b0;
        #1;
        check("mid_rst_outs",
              {sdo, sdo_valid, busy, frame_err, reg_write_readb},
              5'b00000);
        check("mid_rst_num", reg_num, 0);
        check("mid_rst_data", reg_load_data, 0);
        #2;
        resetb = 1'b1;
        tick();
        tick();
        check("post_rst_idle", {busy, sdo_valid}, 2'b00);
        read_check(4'h0, 10'h0B6);

        // Back-to-back write/read of reg 9 with the minimum gap.
        write_check(4'h9, 10'h155, 1'b1);
        read_check(4'h9, 10'h155);

        check("err_total", err_cnt, 1);
        check("invariants", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/veri_phase_comp_serial_host.md
# veri_phase_comp_serial_host

Serial command bridge that gives an external tester or host full access to the phase-compensator register file. It deserialises fixed 15-bit command frames into single-cycle write strobes or read requests on the register-file access port (`reg_num`, `reg_write_readb`, `reg_load_data`, `reg_read_data`). For reads, it serialises the returned 10-bit word back out. It sits between the chip-level serial pins and the phase-compensator control block, on the same clock as that block.

## Interface
- `ADDR_W`, 4: register-number width (16 registers).
- `DATA_W`, 10: register data width.
- `clk`  in  1  block clock, shared with the register file; all logic is on the rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `sen`  in  1  frame enable, active high, synchronous to `clk`.
- `sdi`  in  1  serial data in, MSB first, sampled on every `clk` rising edge while a frame is active.
- `sdo`  out  1  serial read data, MSB first; 0 when `sdo_valid`=0.
- `sdo_valid`  out  1  high while `sdo` carries read data.
- `busy`  out  1  frame or access in progress.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `reg_num`  out  ADDR_W  target register.
- `reg_write_readb`  out  1  write strobe, high for exactly 1 cycle per write; 0 otherwise (read mode).
- `reg_load_data`  out  DATA_W  write data.
- `reg_read_data`  in  DATA_W  combinational read data from the register file for `reg_num` while `reg_write_readb`=0.

## Operation
- Frame format is 15 bits, MSB first:
  - bit14 = W/Rb.
  - bits13:10 = register number.
  - bits9:0 = data. The data field is ignored for reads but must still be clocked.
- States: IDLE, SHIFT_IN, WRITE, READ_CAP, SHIFT_OUT, WAIT_LOW.
- IDLE:
  - A frame starts on the first edge where `sen`=1 and the registered previous `sen`=0.
  - `sdi` is captured on that same edge as bit14, and the state moves to SHIFT_IN.
  - `sen` held high continuously from reset never starts a frame.
- SHIFT_IN:
  - One bit is captured per edge while `sen`=1, with a 4-bit bit counter.
  - On the edge capturing the 15th bit, the state goes to WRITE (W/Rb=1) or READ_CAP (W/Rb=0).
  - `reg_num` and `reg_load_data` update on that same edge.
  - If `sen`=0 on any edge before the 15th bit: discard the frame, pulse `frame_err` for 1 cycle, go to IDLE. No register access occurs and `reg_num`/`reg_load_data` keep their prior values.
- WRITE:
  - `reg_write_readb`=1 for this single cycle.
  - Next state is WAIT_LOW.
- READ_CAP:
  - `reg_write_readb`=0 and `reg_num` is stable.
  - On the exit edge, `reg_read_data` is loaded into a 10-bit shift register.
  - `sdo_valid` is set and `sdo` = captured bit9; next state is SHIFT_OUT.
- SHIFT_OUT:
  - The shift register moves left each edge, for 10 valid cycles total (bit9 down to bit0).
  - `sen` activity during SHIFT_OUT is ignored.
  - After the 10th valid cycle: `sdo_valid`=0, `sdo`=0, next state is WAIT_LOW.
- WAIT_LOW:
  - The state stays here until `sen`=0 is sampled, then goes to IDLE.
  - Extra bits clocked while `sen` remains high are ignored.
  - A new frame therefore requires a fresh `sen` rising edge.
- `busy`=1 in every state except IDLE.
- `reg_num` and `reg_load_data` hold their last values between frames.

## Timing
- Reset values: `reg_num`=0, `reg_load_data`=0, `reg_write_readb`=0, `sdo`=0, `sdo_valid`=0, `busy`=0, `frame_err`=0. Internal state = IDLE, counters = 0, previous-`sen` = 0.
- Reset assertion mid-frame, mid-write or mid-shift-out forces all of the above immediately (asynchronously). The partial operation is lost and no strobe is emitted afterward.
- Let edge N capture bit0:
  - Write: the strobe is high between edges N and N+1, and the register file loads on edge N+1.
  - Read: `reg_read_data` is sampled at edge N+1, and `sdo_valid` is high from edge N+1 to edge N+11.
- Minimum frame-to-frame spacing:
  - Write: 15 bits, the WRITE cycle, then `sen` low for ≥1 edge.
  - Read: 15 bits, 1 capture cycle, 10 output cycles, then `sen` low for ≥1 edge.
- `reg_write_readb` is never high for two consecutive cycles.
- `frame_err` and `reg_write_readb` are never high in the same cycle.

## Test plan
- Write reg 5 with 0x2A5 (frame 1_0101_1010100101): `reg_write_readb` is high for exactly 1 cycle after the 15th bit, with `reg_num`=5 and `reg_load_data`=0x2A5; `busy` falls after `sen` goes low.
- Read reg 7 with the model returning 0x1C3: `reg_num`=7 and `reg_write_readb`=0 throughout; `sdo` = 0,1,1,1,0,0,0,0,1,1 over 10 `sdo_valid` cycles starting 2 edges after the last bit.
- Abort: drop `sen` after 9 bits: `frame_err` pulses once, there is no strobe, `reg_num`/`reg_load_data` are unchanged, and a following full write to reg 0xF with 0x3FF succeeds.
- Hold `sen` high for 20 bits on a write to reg 2 with 0x001: exactly one strobe; no second frame starts until `sen` toggles low then high.
- Assert `resetb` low during the 4th shift-out bit of a read: all outputs return to reset values at once; the next read of reg 0 returns correct data.
- Back-to-back write then read of reg 9 (0x155), with a 1-cycle `sen` low gap: the read returns 0x155 serially, and `busy`/`sdo_valid` follow the timing above.
